mmi_initiator: RTL and testbench

- Bus-master end of the MMI register interface: converts single-word requests from a local client (sequencer, debug bridge, CP controller) into MMI transactions toward any MMI responder (register RAM, peripherals).
- Handles the handshake, registered read-data return and a watchdog timeout.
- Returns one response per request.
- One outstanding transaction at a time.

---
 rtl/mmi_initiator.sv | 160 ++++++++++++++++
 tb/tb_mmi_initiator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmi_initiator.sv
// MMI bus master: turns single-word client requests into one MMI transaction each,
// returning one response pulse with registered read data or a timeout error.
module mmi_initiator #(
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 32,
   parameter int RD_LAT  = 1,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic [7:0]          err_cnt,
   output logic                mmi_valid,
   output logic [DATA_W/8-1:0] mmi_wstrb,
   input  logic                mmi_ready,
   output logic [DATA_W-1:0]   o_mmi_wdata,
   output logic [ADDR_W-1:0]   o_mmi_addr,
   input  logic [DATA_W-1:0]   i_mmi_rdata
);

   localparam int STRB_W = DATA_W / 8;
   localparam logic [2:0] RD_LAT_L     = 3'(RD_LAT);
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, RDWAIT, RESP} state_t;

   state_t              state_q, state_d;
   logic                mmi_valid_q, mmi_valid_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                wr_q, wr_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic [7:0]          err_cnt_q, err_cnt_d;
   logic [7:0]          wait_q, wait_d;
   logic [2:0]          lat_q, lat_d;

   always_comb begin
      state_d     = state_q;
      mmi_valid_d = mmi_valid_q;
      wstrb_d     = wstrb_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wr_d        = wr_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      err_cnt_d   = err_cnt_q;
      wait_d      = wait_q;
      lat_d       = lat_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               // All-zero strobes mean "read" on MMI, so reads never leak client strobes
               wstrb_d     = req_write ? req_wstrb : '0;
               wr_d        = req_write;
               wait_d      = 8'd0;
               mmi_valid_d = 1'b1;
               state_d     = REQ;
            end
         end
         REQ: begin
            if (mmi_valid_q && mmi_ready) begin
               mmi_valid_d = 1'b0;
               if (wr_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = '0;
                  rsp_err_d   = 1'b0;
                  state_d     = RESP;
               end else begin
                  lat_d   = RD_LAT_L;
                  state_d = RDWAIT;
               end
            end else if (wait_q == TIMEOUT_LAST) begin
               // A handshake in this same cycle took the branch above, so it wins
               mmi_valid_d = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               if (err_cnt_q != 8'hFF) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
               state_d = RESP;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         RDWAIT: begin
            if (lat_q <= 3'd1) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = i_mmi_rdata;
               rsp_err_d   = 1'b0;
               state_d     = RESP;
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mmi_valid_q <= 1'b0;
         wstrb_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         err_cnt_q   <= 8'd0;
         wait_q      <= 8'd0;
         lat_q       <= 3'd0;
      end else begin
         state_q     <= state_d;
         mmi_valid_q <= mmi_valid_d;
         wstrb_q     <= wstrb_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wr_q        <= wr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         err_cnt_q   <= err_cnt_d;
         wait_q      <= wait_d;
         lat_q       <= lat_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign mmi_valid   = mmi_valid_q;
   assign mmi_wstrb   = wstrb_q;
   assign o_mmi_addr  = addr_q;
   assign o_mmi_wdata = wdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_mmi_initiator.sv
// Directed bench for mmi_initiator with a small byte-strobed responder holding
// registered read data and a programmable number of wait states.
module tb_mmi_initiator;

   localparam int ADDR_W  = 3;
   localparam int DATA_W  = 32;
   localparam int RD_LAT  = 1;
   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [7:0]  err_cnt;
   logic        mmi_valid, mmi_ready;
   logic [3:0]  mmi_wstrb;
   logic [31:0] o_mmi_wdata;
   logic [2:0]  o_mmi_addr;
   logic [31:0] i_mmi_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] mem [8];
   logic [31:0] rdata_q;
   int          wait_seen = 0;
   int          stall_req;

   always #5 clk = ~clk;

   mmi_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_cnt(err_cnt),
      .mmi_valid(mmi_valid), .mmi_wstrb(mmi_wstrb), .mmi_ready(mmi_ready),
      .o_mmi_wdata(o_mmi_wdata), .o_mmi_addr(o_mmi_addr), .i_mmi_rdata(i_mmi_rdata)
   );

   // Responder: accepts after stall_req wait cycles, registers read data on the handshake
   assign mmi_ready   = mmi_valid && (wait_seen >= stall_req);
   assign i_mmi_rdata = rdata_q;

   always @(posedge clk) begin
      if (!mmi_valid) wait_seen <= 0;
      else if (!mmi_ready) wait_seen <= wait_seen + 1;
      if (mmi_valid && mmi_ready) begin
         rdata_q <= mem[o_mmi_addr];
         for (int b = 0; b < 4; b++)
            if (mmi_wstrb[b]) mem[o_mmi_addr][8*b +: 8] <= o_mmi_wdata[8*b +: 8];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issues one request from IDLE; lat counts cycles from acceptance (C0) to rsp_valid
   task automatic txn(input logic wr, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int lat, output int vcnt,
                      output logic [31:0] rd, output logic er, output logic stable);
      logic [3:0] exp_s;
      exp_s  = wr ? s : 4'h0;
      lat    = -1;
      vcnt   = 0;
      rd     = '0;
      er     = 1'b0;
      stable = 1'b1;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
      for (int i = 1; i <= 40; i++) begin
         step();
         req_valid = 1'b0;
         if (mmi_valid) begin
            vcnt++;
            if (o_mmi_addr !== a || o_mmi_wdata !== d || mmi_wstrb !== exp_s) stable = 1'b0;
         end
         if (rsp_valid) begin
            lat = i;
            rd  = rsp_rdata;
            er  = rsp_err;
            break;
         end
      end
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, vcnt, seen;
      logic [31:0] rd;
      logic        er, stable;
      logic [5:0]  vpat, rpat;

      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_wstrb = '0; stall_req = 0;
      #12;
      chk("reset_mmi_valid", 32'(mmi_valid), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_err_cnt", 32'(err_cnt), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      step();

      // Write, zero-wait
      txn(1'b1, 3'd3, 32'hDEADBEEF, 4'hF, lat, vcnt, rd, er, stable);
      chk("wr_latency", 32'(lat), 32'd2);
      chk("wr_valid_cycles", 32'(vcnt), 32'd1);
      chk("wr_stable", 32'(stable), 32'd1);
      chk("wr_err", 32'(er), 32'd0);
      chk("wr_rdata", rd, 32'd0);
      chk("wr_mem3", mem[3], 32'hDEADBEEF);
      chk("wr_back_idle", 32'(req_ready), 32'd1);

      // Read back
      txn(1'b0, 3'd3, 32'h0, 4'hF, lat, vcnt, rd, er, stable);
      chk("rd_latency", 32'(lat), 32'd3);
      chk("rd_valid_cycles", 32'(vcnt), 32'd1);
      chk("rd_wstrb_zero", 32'(stable), 32'd1);
      chk("rd_data", rd, 32'hDEADBEEF);
      chk("rd_rdata_hold", rsp_rdata, 32'hDEADBEEF);

      // Partial write
      txn(1'b1, 3'd5, 32'h11223344, 4'hF, lat, vcnt, rd, er, stable);
      txn(1'b1, 3'd5, 32'h0000AB00, 4'h2, lat, vcnt, rd, er, stable);
      chk("pw_stable", 32'(stable), 32'd1);
      txn(1'b0, 3'd5, 32'h0, 4'h0, lat, vcnt, rd, er, stable);
      chk("pw_read", rd, 32'h1122AB44);

      // req_valid held high: accepted again only after RESP
      req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd4; req_wdata = 32'h0BADCAFE; req_wstrb = 4'hF;
      for (int i = 0; i < 6; i++) begin
         step();
         vpat[i] = mmi_valid;
         rpat[i] = rsp_valid;
      end
      req_valid = 1'b0;
      step();
      chk("held_valid_pattern", 32'(vpat), 32'h09);
      chk("held_rsp_pattern", 32'(rpat), 32'h12);
      chk("held_mem4", mem[4], 32'h0BADCAFE);

      // Four wait states
      stall_req = 4;
      txn(1'b1, 3'd1, 32'hCAFEF00D, 4'hF, lat, vcnt, rd, er, stable);
      chk("ws_valid_cycles", 32'(vcnt), 32'd5);
      chk("ws_stable", 32'(stable), 32'd1);
      chk("ws_latency", 32'(lat), 32'd6);
      chk("ws_err", 32'(er), 32'd0);
      chk("ws_mem1", mem[1], 32'hCAFEF00D);

      // Timeouts
      stall_req = 1000;
      txn(1'b0, 3'd3, 32'h0, 4'h0, lat, vcnt, rd, er, stable);
      chk("to1_valid_cycles", 32'(vcnt), 32'd15);
      chk("to1_latency", 32'(lat), 32'd16);
      chk("to1_err", 32'(er), 32'd1);
      chk("to1_rdata", rd, 32'd0);
      chk("to1_err_cnt", 32'(err_cnt), 32'd1);
      txn(1'b1, 3'd2, 32'h12345678, 4'hF, lat, vcnt, rd, er, stable);
      chk("to2_err", 32'(er), 32'd1);
      chk("to2_err_cnt", 32'(err_cnt), 32'd2);

      // Ready on the 15th cycle: handshake wins
      stall_req = 14;
      txn(1'b1, 3'd2, 32'h55AA55AA, 4'hF, lat, vcnt, rd, er, stable);
      chk("late_valid_cycles", 32'(vcnt), 32'd15);
      chk("late_latency", 32'(lat), 32'd16);
      chk("late_err", 32'(er), 32'd0);
      chk("late_err_cnt", 32'(err_cnt), 32'd2);
      chk("late_mem2", mem[2], 32'h55AA55AA);

      // Reset while mmi_valid is high
      stall_req = 1000;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd6; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
      step();
      req_valid = 1'b0;
      chk("rst_req_valid_high", 32'(mmi_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_mmi_valid", 32'(mmi_valid), 32'd0);
      chk("rst_async_addr", 32'(o_mmi_addr), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      stall_req = 0;
      @(negedge clk) rst_n = 1'b1;
      step();

      // Reset during RDWAIT
      req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd3; req_wstrb = 4'h0;
      step();
      req_valid = 1'b0;
      step();
      chk("rdw_mmi_valid_low", 32'(mmi_valid), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rdw_rsp_valid_low", 32'(rsp_valid), 32'd0);
      chk("rdw_rsp_rdata", rsp_rdata, 32'd0);
      step();
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         seen += int'(rsp_valid);
      end
      chk("rdw_no_rsp_after_reset", 32'(seen), 32'd0);
      txn(1'b0, 3'd3, 32'h0, 4'h0, lat, vcnt, rd, er, stable);
      chk("post_rst_latency", 32'(lat), 32'd3);
      chk("post_rst_data", rd, 32'hDEADBEEF);
      chk("post_rst_err", 32'(er), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
